// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Sequencer between the multi-cycle datapath and the unified, byte-addressed,
// big-endian main memory. It arbitrates instruction-fetch and load/store
// requests round-robin. It drives a level-sensitive Address / WriteData /
// MemRead / MemWrite interface with setup and hold margins. Read data is
// captured into Instr (fetch) or DRData (load). Misaligned or out-of-range
// accesses are rejected without touching the memory interface.
//
// Handshake: a requester raises *Req and holds it high, with its address,
// write-enable and store data stable, until its *Done pulses for one cycle.
// *Err is valid only while *Done is high. A Req that is still high in the
// cycle after Done is taken as a new request. A Req dropped mid-access does
// not abort the access, and Done still pulses.
//
// Ports
//   Clk, Reset_n              clock (rising edge), async active-low reset
//   IfReq, IfAddr             fetch request / byte address
//   IfDone, IfErr, Instr      fetch completion pulse, reject flag, instr reg
//   DReq, DWe, DAddr, DWData  data request, 1=store 0=load, address, store data
//   DDone, DErr, DRData       data completion pulse, reject flag, data reg
//   Address, WriteData        memory address / store data (held between accesses)
//   MemRead, MemWrite         memory enables (never both high)
//   MemData                   memory read data
//   dbg_state                 current FSM state, for observation
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int MEM_BYTES = 1024,
    parameter int READ_WAIT = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        IfReq,
    input  logic [31:0] IfAddr,
    output logic        IfDone,
    output logic        IfErr,
    output logic [31:0] Instr,
    input  logic        DReq,
    input  logic        DWe,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWData,
    output logic        DDone,
    output logic        DErr,
    output logic [31:0] DRData,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] MemData,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int          CW        = (READ_WAIT > 1) ? $clog2(READ_WAIT + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT  = CW'(READ_WAIT - 1);
    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    state_t        state, state_nxt;
    logic          last_gnt_d;   // 1 = data port was granted last, 0 = fetch
    logic          gnt_d;        // current access belongs to the data port
    logic          gnt_we;       // current access is a store
    logic          err_flag;     // current access was rejected
    logic [CW-1:0] cnt;

    logic          any_req;
    logic          pick_d;
    logic [31:0]   pick_addr;
    logic          legal;

    // Arbitration: a lone requester wins; with both pending, the one that
    // was not granted last wins.
    always_comb begin
        any_req   = IfReq | DReq;
        pick_d    = DReq & (~IfReq | ~last_gnt_d);
        pick_addr = pick_d ? DAddr : IfAddr;
        legal     = (pick_addr[1:0] == 2'b00) && (pick_addr <= LAST_WORD);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_req) state_nxt = legal ? S_SETUP : S_DONE;
            S_SETUP: state_nxt = gnt_we ? S_WRITE : S_READ;
            S_READ:  if (cnt == '0) state_nxt = S_DONE;
            S_WRITE: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Enables and completion flags are decoded straight from the state
    // register, so an asynchronous reset drops them immediately.
    always_comb begin
        MemRead   = (state == S_READ);
        MemWrite  = (state == S_WRITE);
        IfDone    = (state == S_DONE) & ~gnt_d;
        DDone     = (state == S_DONE) &  gnt_d;
        IfErr     = IfDone & err_flag;
        DErr      = DDone  & err_flag;
        dbg_state = state;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= S_IDLE;
            last_gnt_d <= 1'b0;
            gnt_d      <= 1'b0;
            gnt_we     <= 1'b0;
            err_flag   <= 1'b0;
            cnt        <= '0;
            Address    <= '0;
            WriteData  <= '0;
            Instr      <= '0;
            DRData     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        gnt_d      <= pick_d;
                        last_gnt_d <= pick_d;
                        gnt_we     <= pick_d & DWe;
                        err_flag   <= ~legal;
                        // Address and store data are loaded on the grant edge.
                        // They are therefore valid for the whole SETUP cycle,
                        // before any enable rises. A rejected access leaves
                        // them untouched.
                        if (legal) begin
                            Address <= pick_addr;
                            if (pick_d && DWe) WriteData <= DWData;
                        end
                    end
                end
                S_SETUP: cnt <= CNT_INIT;
                S_READ: begin
                    if (cnt == '0) begin
                        if (gnt_d) DRData <= MemData;
                        else       Instr  <= MemData;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        IfReq = 1'b0;
    logic [31:0] IfAddr = '0;
    logic        IfDone, IfErr;
    logic [31:0] Instr;
    logic        DReq = 1'b0;
    logic        DWe = 1'b0;
    logic [31:0] DAddr = '0;
    logic [31:0] DWData = '0;
    logic        DDone, DErr;
    logic [31:0] DRData;
    logic [31:0] Address, WriteData;
    logic        MemRead, MemWrite;
    logic [31:0] MemData;
    logic [2:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    // Memory model: big-endian bytes, combinational read, write on the edge.
    logic [7:0] mem [0:1023];
    int rd_cycles = 0;
    int wr_cycles = 0;
    int both_cycles = 0;

    mem_access_ctrl #(.MEM_BYTES(1024), .READ_WAIT(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .IfReq(IfReq), .IfAddr(IfAddr), .IfDone(IfDone), .IfErr(IfErr), .Instr(Instr),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData),
        .DDone(DDone), .DErr(DErr), .DRData(DRData),
        .Address(Address), .WriteData(WriteData), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemData(MemData), .dbg_state(dbg_state)
    );

    always #5 Clk = ~Clk;

    assign MemData = MemRead ? {mem[Address[9:0]], mem[Address[9:0] + 10'd1],
                                mem[Address[9:0] + 10'd2], mem[Address[9:0] + 10'd3]} : 32'h0;

    always @(posedge Clk) begin
        if (MemRead) rd_cycles++;
        if (MemRead && MemWrite) both_cycles++;
        if (MemWrite) begin
            wr_cycles++;
            mem[Address[9:0]]         <= WriteData[31:24];
            mem[Address[9:0] + 10'd1] <= WriteData[23:16];
            mem[Address[9:0] + 10'd2] <= WriteData[15:8];
            mem[Address[9:0] + 10'd3] <= WriteData[7:0];
        end
    end

    function automatic logic [31:0] mem_word(input int a);
        return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
    endfunction

    task automatic put_word(input int a, input logic [31:0] w);
        mem[a] = w[31:24]; mem[a+1] = w[23:16]; mem[a+2] = w[15:8]; mem[a+3] = w[7:0];
    endtask

    task automatic do_reset();
        IfReq = 1'b0; DReq = 1'b0; DWe = 1'b0;
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    // Counts rising edges from the request until a Done is seen at a falling edge.
    task automatic wait_done(input int max, output int cyc, output bit timeout);
        cyc = 0;
        timeout = 1'b1;
        while (cyc < max) begin
            @(posedge Clk);
            cyc++;
            @(negedge Clk);
            if (IfDone || DDone) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        n_cmp++;
        if ({MemRead, MemWrite, IfDone, IfErr, DDone, DErr} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags: got %b expected 000000",
                              {MemRead, MemWrite, IfDone, IfErr, DDone, DErr});
        end
        n_cmp++;
        if (Address !== 32'h0) begin n_err++; $display("FAIL reset_address: got %h expected 0", Address); end
        n_cmp++;
        if (WriteData !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %h expected 0", WriteData); end
        n_cmp++;
        if (Instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h expected 0", Instr); end
        n_cmp++;
        if (DRData !== 32'h0) begin n_err++; $display("FAIL reset_drdata: got %h expected 0", DRData); end
        n_cmp++;
        if (dbg_state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_fetch();
        int cyc; bit to; int rd0;
        rd0 = rd_cycles;
        IfAddr = 32'h0; IfReq = 1'b1;
        exp_q.push_back(32'h18000064);
        wait_done(12, cyc, to);
        IfReq = 1'b0;
        n_cmp++;
        if (to) begin n_err++; $display("FAIL fetch_timeout: got no IfDone expected IfDone"); end
        n_cmp++;
        if (cyc != 4) begin n_err++; $display("FAIL fetch_latency: got %0d expected 4", cyc); end
        n_cmp++;
        if ({IfDone, IfErr, DDone} !== 3'b100) begin
            n_err++; $display("FAIL fetch_flags: got %b expected 100", {IfDone, IfErr, DDone});
        end
        n_cmp++;
        if (Instr !== exp_q[0]) begin n_err++; $display("FAIL fetch_instr: got %h expected %h", Instr, exp_q[0]); end
        void'(exp_q.pop_front());
        n_cmp++;
        if (rd_cycles - rd0 != 2) begin n_err++; $display("FAIL fetch_read_cycles: got %0d expected 2", rd_cycles - rd0); end
        @(negedge Clk);
    endtask

    task automatic test_store_load();
        int cyc; bit to; int wr0;
        wr0 = wr_cycles;
        DWe = 1'b1; DAddr = 32'd8; DWData = 32'hDEADBEEF; DReq = 1'b1;
        exp_q.push_back(32'hDEADBEEF);
        wait_done(12, cyc, to);
        DReq = 1'b0;
        n_cmp++;
        if (to || cyc != 3) begin n_err++; $display("FAIL store_latency: got %0d (timeout %0d) expected 3", cyc, to); end
        n_cmp++;
        if ({DDone, DErr, MemWrite} !== 3'b100) begin
            n_err++; $display("FAIL store_done: got %b expected 100", {DDone, DErr, MemWrite});
        end
        n_cmp++;
        if (wr_cycles - wr0 != 1) begin n_err++; $display("FAIL store_wr_cycles: got %0d expected 1", wr_cycles - wr0); end
        n_cmp++;
        if (Address !== 32'd8 || WriteData !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL store_hold: got %h/%h expected 00000008/deadbeef", Address, WriteData);
        end
        n_cmp++;
        if (mem_word(8) !== exp_q[0]) begin n_err++; $display("FAIL store_mem: got %h expected %h", mem_word(8), exp_q[0]); end
        @(negedge Clk);
        DWe = 1'b0; DReq = 1'b1;
        wait_done(12, cyc, to);
        DReq = 1'b0;
        n_cmp++;
        if (to || cyc != 4) begin n_err++; $display("FAIL load_latency: got %0d (timeout %0d) expected 4", cyc, to); end
        n_cmp++;
        if (DRData !== exp_q[0]) begin n_err++; $display("FAIL load_data: got %h expected %h", DRData, exp_q[0]); end
        void'(exp_q.pop_front());
        @(negedge Clk);
    endtask

    task automatic test_arbitration();
        int cyc; bit to; logic [31:0] obs;
        do_reset();
        IfAddr = 32'h10; DAddr = 32'h20; DWe = 1'b0;
        exp_q.push_back(32'hAAAA0020);
        exp_q.push_back(32'h11110010);
        exp_q.push_back(32'hAAAA0020);
        exp_q.push_back(32'h11110010);
        IfReq = 1'b1; DReq = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_done(12, cyc, to);
            obs = DDone ? DRData : Instr;
            n_cmp++;
            if (to || (IfDone && DDone)) begin
                n_err++; $display("FAIL arb_done_%0d: got timeout=%0d both=%0d expected one Done", k, to, IfDone && DDone);
            end
            n_cmp++;
            if (obs !== exp_q[0]) begin n_err++; $display("FAIL arb_grant_%0d: got %h expected %h", k, obs, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        IfReq = 1'b0; DReq = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_errors();
        int cyc; bit to; int rd0; int wr0;
        logic [31:0] bad_addr [2];
        logic        bad_we [2];
        bad_addr[0] = 32'd6;    bad_we[0] = 1'b0;
        bad_addr[1] = 32'd1024; bad_we[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rd0 = rd_cycles; wr0 = wr_cycles;
            exp_q.push_back(32'hAAAA0020);
            DAddr = bad_addr[k]; DWe = bad_we[k]; DWData = 32'h55555555; DReq = 1'b1;
            wait_done(12, cyc, to);
            DReq = 1'b0;
            n_cmp++;
            if (to || cyc != 1) begin n_err++; $display("FAIL err_latency_%0d: got %0d (timeout %0d) expected 1", k, cyc, to); end
            n_cmp++;
            if ({DDone, DErr} !== 2'b11) begin n_err++; $display("FAIL err_flags_%0d: got %b expected 11", k, {DDone, DErr}); end
            n_cmp++;
            if ((rd_cycles - rd0) + (wr_cycles - wr0) != 0) begin
                n_err++; $display("FAIL err_mem_touch_%0d: got %0d enable cycles expected 0", k, (rd_cycles - rd0) + (wr_cycles - wr0));
            end
            n_cmp++;
            if (DRData !== exp_q[0]) begin n_err++; $display("FAIL err_drdata_%0d: got %h expected %h", k, DRData, exp_q[0]); end
            void'(exp_q.pop_front());
            n_cmp++;
            if (Address !== 32'h10) begin n_err++; $display("FAIL err_address_%0d: got %h expected 00000010", k, Address); end
            @(negedge Clk);
        end
        // Misaligned fetch leaves Instr alone.
        exp_q.push_back(32'h11110010);
        IfAddr = 32'd2; IfReq = 1'b1;
        wait_done(12, cyc, to);
        IfReq = 1'b0;
        n_cmp++;
        if (to || {IfDone, IfErr} !== 2'b11) begin n_err++; $display("FAIL ferr_flags: got %b (timeout %0d) expected 11", {IfDone, IfErr}, to); end
        n_cmp++;
        if (Instr !== exp_q[0]) begin n_err++; $display("FAIL ferr_instr: got %h expected %h", Instr, exp_q[0]); end
        void'(exp_q.pop_front());
        @(negedge Clk);
        // Highest legal word address.
        exp_q.push_back(32'hCAFEF00D);
        DAddr = 32'd1020; DWe = 1'b0; DReq = 1'b1;
        wait_done(12, cyc, to);
        DReq = 1'b0;
        n_cmp++;
        if (to || cyc != 4 || DErr !== 1'b0) begin n_err++; $display("FAIL top_word_access: got cyc=%0d err=%b expected 4/0", cyc, DErr); end
        n_cmp++;
        if (DRData !== exp_q[0]) begin n_err++; $display("FAIL top_word_data: got %h expected %h", DRData, exp_q[0]); end
        void'(exp_q.pop_front());
        @(negedge Clk);
    endtask

    task automatic test_reset_mid_write();
        int waited; bit seen_done;
        exp_q.push_back(32'h0);
        DWe = 1'b1; DAddr = 32'd12; DWData = 32'h12345678; DReq = 1'b1;
        waited = 0;
        while (MemWrite !== 1'b1 && waited < 12) begin
            @(negedge Clk);
            waited++;
        end
        n_cmp++;
        if (MemWrite !== 1'b1) begin n_err++; $display("FAIL rst_wr_reach: got MemWrite=%b expected 1", MemWrite); end
        Reset_n = 1'b0;
        DReq = 1'b0;
        #1;
        n_cmp++;
        if (MemWrite !== 1'b0 || dbg_state !== 3'd0) begin
            n_err++; $display("FAIL rst_wr_drop: got MemWrite=%b state=%0d expected 0/0", MemWrite, dbg_state);
        end
        seen_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            if (DDone) seen_done = 1'b1;
        end
        Reset_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk);
            if (DDone) seen_done = 1'b1;
        end
        n_cmp++;
        if (seen_done) begin n_err++; $display("FAIL rst_wr_nodone: got DDone expected none"); end
        n_cmp++;
        if ({Address, WriteData, Instr, DRData, MemRead, MemWrite, IfDone, IfErr, DDone, DErr} !== '0) begin
            n_err++; $display("FAIL rst_wr_outputs: got addr=%h wd=%h instr=%h dr=%h expected all 0", Address, WriteData, Instr, DRData);
        end
        n_cmp++;
        if (mem_word(12) !== exp_q[0]) begin n_err++; $display("FAIL rst_wr_mem: got %h expected %h", mem_word(12), exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        put_word(0, 32'h18000064);
        put_word(16, 32'h11110010);
        put_word(32, 32'hAAAA0020);
        put_word(1020, 32'hCAFEF00D);
        @(negedge Clk);
        test_reset();
        test_fetch();
        test_store_load();
        test_arbitration();
        test_errors();
        test_reset_mid_write();
        n_cmp++;
        if (both_cycles != 0) begin n_err++; $display("FAIL enables_exclusive: got %0d overlap cycles expected 0", both_cycles); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
